// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU path: FSM states, op encoding
// and the bit-counter sizing helper.
package alu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_alu_seq_fa.sv
// Existing 1-bit full-adder cell, time-shared by the serial sequencer.
module FullAdder (
    output logic s,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial add/subtract: one full-adder cell walks the operands LSB first,
// one bit per cycle, with a carry flip-flop between bits.
module serial_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             fa_s, fa_c;
    logic             last_bit;

    FullAdder u_fa (
        .s    (fa_s),
        .cout (fa_c),
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sr_d     = sr_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sr_d    = {fa_s, sr_q[WIDTH-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                // Visible outputs only move once the whole word is assembled.
                if (last_bit) begin
                    result_d = {fa_s, sr_q[WIDTH-1:1]};
                    cout_d   = fa_c;
                    ovf_d    = carry_q ^ fa_c;
                    state_d  = S_DONE;
                end
            end
            default: begin
                if (start) begin
                    a_d     = a;
                    b_d     = (op == OP_SUB) ? ~b : b;
                    carry_d = (op == OP_SUB);
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sr_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sr_q     <= sr_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ready  = (state_q != S_RUN);
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule
